// File: rtl/neural_layer_mac.sv
// Fully-connected layer evaluator: LANES neurons accumulate in parallel per group,
// followed by an optional ReLU and an argmax scan over all OUT_SIZE results.

module nlm_fp_pack (
    input  logic               i_s,
    input  logic signed [11:0] i_e,
    input  logic [26:0]        i_n,
    output logic [31:0]        o_y
);
    // i_n = {hidden, frac[22:0], guard, round, sticky}; round-to-nearest-even, flush tiny to zero
    logic               w_up;
    logic [23:0]        w_m;
    logic signed [11:0] w_e;

    always_comb begin
        w_up = i_n[2] & (i_n[1] | i_n[0] | i_n[3]);
        w_m  = {1'b0, i_n[25:3]} + {23'b0, w_up};
        w_e  = w_m[23] ? i_e + 12'sd1 : i_e;
        if (!i_n[26] || w_e <= 12'sd0) o_y = {i_s, 31'b0};
        else if (w_e >= 12'sd255)      o_y = {i_s, 8'hFF, 23'b0};
        else                           o_y = {i_s, w_e[7:0], w_m[22:0]};
    end
endmodule

module nlm_fp_mul (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y
);
    logic               w_s, w_nan, w_inf, w_zero;
    logic [47:0]        w_prod;
    logic [26:0]        w_n;
    logic signed [11:0] w_e;
    logic [31:0]        w_pack;

    assign w_s    = i_a[31] ^ i_b[31];
    assign w_zero = ~|i_a[30:23] | ~|i_b[30:23];
    assign w_inf  = &i_a[30:23] | &i_b[30:23];
    assign w_nan  = (&i_a[30:23] & |i_a[22:0]) | (&i_b[30:23] & |i_b[22:0]) | (w_inf & w_zero);
    assign w_prod = {24'b0, 1'b1, i_a[22:0]} * {24'b0, 1'b1, i_b[22:0]};

    always_comb begin
        w_e = $signed({4'b0, i_a[30:23]}) + $signed({4'b0, i_b[30:23]}) - 12'sd127;
        if (w_prod[47]) begin
            w_n = {w_prod[47:22], |w_prod[21:0]};
            w_e = w_e + 12'sd1;
        end else begin
            w_n = {w_prod[46:21], |w_prod[20:0]};
        end
    end

    nlm_fp_pack u_pack (.i_s(w_s), .i_e(w_e), .i_n(w_n), .o_y(w_pack));

    always_comb begin
        if (w_nan)       o_y = 32'h7FC00000;
        else if (w_inf)  o_y = {w_s, 8'hFF, 23'b0};
        else if (w_zero) o_y = {w_s, 31'b0};
        else             o_y = w_pack;
    end
endmodule

module nlm_fp_add (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y
);
    logic               w_swap, w_stk, w_cancel;
    logic [31:0]        w_big, w_sml, w_pack;
    logic [7:0]         w_d;
    logic [26:0]        w_mb, w_ms, w_sh, w_n;
    logic [27:0]        w_sum;
    logic signed [11:0] w_e;
    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    int                 w_lz;

    assign w_a_zero = ~|i_a[30:23];
    assign w_b_zero = ~|i_b[30:23];
    assign w_a_inf  = &i_a[30:23] & ~|i_a[22:0];
    assign w_b_inf  = &i_b[30:23] & ~|i_b[22:0];
    assign w_a_nan  = &i_a[30:23] & |i_a[22:0];
    assign w_b_nan  = &i_b[30:23] & |i_b[22:0];
    assign w_swap   = i_b[30:0] > i_a[30:0];
    assign w_big    = w_swap ? i_b : i_a;
    assign w_sml    = w_swap ? i_a : i_b;

    always_comb begin
        w_d  = w_big[30:23] - w_sml[30:23];
        w_mb = {1'b1, w_big[22:0], 3'b0};
        w_ms = {1'b1, w_sml[22:0], 3'b0};
        if (w_d >= 8'd27) begin
            w_sh  = '0;
            w_stk = 1'b1;
        end else begin
            w_sh  = w_ms >> w_d;
            w_stk = |(w_ms & ~({27{1'b1}} << w_d));
        end
        w_sh[0]  = w_sh[0] | w_stk;
        w_e      = $signed({4'b0, w_big[30:23]});
        w_n      = '0;
        w_lz     = 0;
        w_cancel = 1'b0;
        if (w_big[31] == w_sml[31]) begin
            w_sum = {1'b0, w_mb} + {1'b0, w_sh};
            if (w_sum[27]) begin
                w_n = {w_sum[27:2], |w_sum[1:0]};
                w_e = w_e + 12'sd1;
            end else begin
                w_n = w_sum[26:0];
            end
        end else begin
            w_sum    = {1'b0, w_mb} - {1'b0, w_sh};
            w_cancel = (w_sum == '0);
            for (int k = 0; k < 27; k++) if (w_sum[k]) w_lz = 26 - k;
            w_n = w_sum[26:0] << w_lz;
            w_e = w_e - 12'(w_lz);
        end
    end

    nlm_fp_pack u_pack (.i_s(w_big[31]), .i_e(w_e), .i_n(w_n), .o_y(w_pack));

    always_comb begin
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && i_a[31] != i_b[31])) o_y = 32'h7FC00000;
        else if (w_a_inf)              o_y = i_a;
        else if (w_b_inf)              o_y = i_b;
        else if (w_a_zero && w_b_zero) o_y = {i_a[31] & i_b[31], 31'b0};
        else if (w_a_zero)             o_y = i_b;
        else if (w_b_zero)             o_y = i_a;
        else if (w_cancel)             o_y = 32'h0;
        else                           o_y = w_pack;
    end
endmodule

module nlm_lane (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_mac,
    input  logic [31:0] i_bias,
    input  logic [31:0] i_x,
    input  logic [31:0] i_w,
    output logic [31:0] o_acc
);
    logic [31:0] r_acc, w_prod, w_sum;

    nlm_fp_mul u_mul (.i_a(i_x), .i_b(i_w), .o_y(w_prod));
    nlm_fp_add u_add (.i_a(r_acc), .i_b(w_prod), .o_y(w_sum));

    always_ff @(posedge i_clk) begin
        if (i_rst)       r_acc <= '0;
        else if (i_load) r_acc <= i_bias;
        else if (i_mac)  r_acc <= w_sum;
    end

    assign o_acc = r_acc;
endmodule

module neural_layer_mac #(
    parameter int IN_SIZE    = 784,
    parameter int OUT_SIZE   = 10,
    parameter int LANES      = 1,
    parameter int ACTIVATION = 1
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [32*IN_SIZE-1:0]                             in,
    input  logic [32*IN_SIZE*OUT_SIZE-1:0]                    weights,
    input  logic [32*OUT_SIZE-1:0]                            bias,
    output logic                                              busy,
    output logic                                              done,
    output logic [32*OUT_SIZE-1:0]                            result,
    output logic [((OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1)-1:0] argmax
);
    localparam int G  = OUT_SIZE / LANES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int AW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int WW = (IN_SIZE * OUT_SIZE > 1) ? $clog2(IN_SIZE * OUT_SIZE) : 1;

    typedef enum logic [2:0] {IDLE, INIT, MAC, WB, ARG, DONE} state_t;

    state_t                             r_state;
    logic [GW-1:0]                      r_g;
    logic [IW-1:0]                      r_i;
    logic [AW-1:0]                      r_k, r_best_idx, r_argmax;
    logic [31:0]                        r_best_val;
    logic                               r_best_ok, r_busy, r_done;
    logic [OUT_SIZE-1:0][31:0]          r_result;

    logic [IN_SIZE-1:0][31:0]           w_x;
    logic [IN_SIZE*OUT_SIZE-1:0][31:0]  w_w;
    logic [OUT_SIZE-1:0][31:0]          w_b;
    logic [LANES-1:0][31:0]             w_acc, w_act;
    logic [LANES-1:0][AW-1:0]           w_ridx;
    logic [31:0]                        w_cur;
    logic                               w_cur_nan, w_take;

    assign w_x = in;
    assign w_w = weights;
    assign w_b = bias;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [WW-1:0] w_widx;
        assign w_ridx[l] = AW'(int'(r_g) * LANES + l);
        assign w_widx    = WW'((int'(r_g) * LANES + l) * IN_SIZE + int'(r_i));

        nlm_lane u_lane (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_load (r_state == INIT),
            .i_mac  (r_state == MAC),
            .i_bias (w_b[w_ridx[l]]),
            .i_x    (w_x[r_i]),
            .i_w    (w_w[w_widx]),
            .o_acc  (w_acc[l])
        );

        // ReLU keys purely on the sign bit, so -0 and negative NaN both clamp to +0
        assign w_act[l] = (ACTIVATION == 1 && w_acc[l][31]) ? 32'h0 : w_acc[l];
    end

    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ka, kb;
        ka = a[31] ? ~a : {1'b1, a[30:0]};
        kb = b[31] ? ~b : {1'b1, b[30:0]};
        return (|a[30:0] || |b[30:0]) && (ka > kb);
    endfunction

    assign w_cur     = r_result[r_k];
    assign w_cur_nan = &w_cur[30:23] & |w_cur[22:0];
    assign w_take    = !w_cur_nan && (r_k == '0 || !r_best_ok || fp_gt(w_cur, r_best_val));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_g        <= '0;
            r_i        <= '0;
            r_k        <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
            r_best_ok  <= 1'b0;
            r_argmax   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_state <= INIT;
                    r_g     <= '0;
                    r_busy  <= 1'b1;
                end
                INIT: begin
                    r_i     <= '0;
                    r_state <= MAC;
                end
                MAC: begin
                    if (r_i == IW'(IN_SIZE - 1)) r_state <= WB;
                    else                         r_i     <= r_i + 1'b1;
                end
                WB: begin
                    for (int l = 0; l < LANES; l++) r_result[w_ridx[l]] <= w_act[l];
                    if (r_g == GW'(G - 1)) begin
                        r_state <= ARG;
                        r_k     <= '0;
                    end else begin
                        r_g     <= r_g + 1'b1;
                        r_state <= INIT;
                    end
                end
                ARG: begin
                    // index 0 always seeds the scan so an all-NaN layer reports 0
                    if (w_take || r_k == '0) begin
                        r_best_idx <= r_k;
                        r_best_val <= w_cur;
                    end
                    r_best_ok <= w_take | (r_best_ok & (r_k != '0));
                    if (r_k == AW'(OUT_SIZE - 1)) begin
                        r_argmax <= w_take ? r_k : r_best_idx;
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign argmax = r_argmax;
endmodule

// File: tb/tb_neural_layer_mac.sv
// Scoreboard bench: three layer instances (ReLU, identity, two lanes) share stimulus;
// expectations are queued at start and compared when each instance pulses done.
module tb_neural_layer_mac;
    logic         clk = 1'b0;
    logic         rst, start;
    logic [63:0]  in;
    logic [127:0] weights;
    logic [63:0]  bias;
    logic         busy_a, done_a, busy_l, done_l, busy_w, done_w;
    logic [63:0]  result_a, result_l, result_w;
    logic [0:0]   argmax_a, argmax_l, argmax_w;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    neural_layer_mac #(.IN_SIZE(2), .OUT_SIZE(2), .LANES(1), .ACTIVATION(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in(in), .weights(weights), .bias(bias),
        .busy(busy_a), .done(done_a), .result(result_a), .argmax(argmax_a));
    neural_layer_mac #(.IN_SIZE(2), .OUT_SIZE(2), .LANES(1), .ACTIVATION(0)) dut_l (
        .clk(clk), .rst(rst), .start(start), .in(in), .weights(weights), .bias(bias),
        .busy(busy_l), .done(done_l), .result(result_l), .argmax(argmax_l));
    neural_layer_mac #(.IN_SIZE(2), .OUT_SIZE(2), .LANES(2), .ACTIVATION(1)) dut_w (
        .clk(clk), .rst(rst), .start(start), .in(in), .weights(weights), .bias(bias),
        .busy(busy_w), .done(done_w), .result(result_w), .argmax(argmax_w));

    typedef struct {
        logic [63:0] res;
        logic        am;
        int          at;
        bit          r0nan;
    } exp_t;

    exp_t q_a[$], q_l[$], q_w[$];
    int   n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic isnan(input logic [31:0] x);
        return (&x[30:23]) & (|x[22:0]);
    endfunction

    task automatic mon_cmp(input string nm, input exp_t e, input logic [63:0] res,
                           input logic am, input logic bsy);
        check({nm, "_done_edge"}, 64'(cyc), 64'(e.at));
        if (e.r0nan) check({nm, "_r0_nan"}, 64'(isnan(res[31:0])), 64'd1);
        else         check({nm, "_r0"}, 64'(res[31:0]), 64'(e.res[31:0]));
        check({nm, "_r1"}, 64'(res[63:32]), 64'(e.res[63:32]));
        check({nm, "_argmax"}, 64'(am), 64'(e.am));
        check({nm, "_busy_at_done"}, 64'(bsy), 64'd0);
    endtask

    always @(negedge clk) if (done_a) begin
        check("a_done_expected", 64'(q_a.size() != 0), 64'd1);
        if (q_a.size() != 0) mon_cmp("a", q_a.pop_front(), result_a, argmax_a[0], busy_a);
    end
    always @(negedge clk) if (done_l) begin
        check("l_done_expected", 64'(q_l.size() != 0), 64'd1);
        if (q_l.size() != 0) mon_cmp("l", q_l.pop_front(), result_l, argmax_l[0], busy_l);
    end
    always @(negedge clk) if (done_w) begin
        check("w_done_expected", 64'(q_w.size() != 0), 64'd1);
        if (q_w.size() != 0) mon_cmp("w", q_w.pop_front(), result_w, argmax_w[0], busy_w);
    end

    // s is the edge that samples start; single-lane layers finish 10 edges later, two-lane 6
    task automatic push_all(input logic [63:0] r_relu, input logic am_relu,
                            input logic [63:0] r_lin, input logic am_lin, input bit nan0, input int s);
        q_a.push_back('{r_relu, am_relu, s + 10, nan0});
        q_l.push_back('{r_lin,  am_lin,  s + 10, nan0});
        q_w.push_back('{r_relu, am_relu, s + 6,  nan0});
    endtask

    task automatic set_stim(input logic [31:0] x0, x1, w00, w01, w10, w11, b0, b1);
        in      = {x1, x0};
        weights = {w11, w10, w01, w00};
        bias    = {b1, b0};
    endtask

    task automatic drain();
        int t = 0;
        while ((q_a.size() + q_l.size() + q_w.size()) != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("queues_drained", 64'(q_a.size() + q_l.size() + q_w.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic eval(input logic [63:0] r_relu, input logic am_relu,
                        input logic [63:0] r_lin, input logic am_lin, input bit nan0);
        @(negedge clk);
        start = 1'b1;
        push_all(r_relu, am_relu, r_lin, am_lin, nan0, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        drain();
        check("a_hold_r1", 64'(result_a[63:32]), 64'(r_relu[63:32]));
        check("l_hold_r1", 64'(result_l[63:32]), 64'(r_lin[63:32]));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_a_busy"}, 64'(busy_a), 64'd0);
        check({tag, "_a_done"}, 64'(done_a), 64'd0);
        check({tag, "_a_result"}, result_a, 64'd0);
        check({tag, "_a_argmax"}, 64'(argmax_a), 64'd0);
        check({tag, "_l_busy"}, 64'(busy_l), 64'd0);
        check({tag, "_l_result"}, result_l, 64'd0);
        check({tag, "_l_argmax"}, 64'(argmax_l), 64'd0);
        check({tag, "_w_busy"}, 64'(busy_w), 64'd0);
        check({tag, "_w_done"}, 64'(done_w), 64'd0);
        check({tag, "_w_result"}, result_w, 64'd0);
    endtask

    localparam logic [31:0] F0 = 32'h00000000, FN0 = 32'h80000000, FH = 32'h3F000000;
    localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, FM1 = 32'hBF800000;
    localparam logic [31:0] QN = 32'h7FC00000;

    task automatic base_stim();
        set_stim(F1, F2, FH, FH, FM1, FM1, F0, FH);
    endtask

    initial begin
        int s;
        rst = 1'b1;
        start = 1'b0;
        base_stim();
        repeat (2) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;

        // 0.5+1.0 = 1.5 ; 0.5-1-2 = -2.5 (clamped under ReLU)
        eval({F0, 32'h3FC00000}, 1'b0, {32'hC0200000, 32'h3FC00000}, 1'b0, 1'b0);

        // start held high: one done per evaluation, IDLE between them
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        push_all({F0, 32'h3FC00000}, 1'b0, {32'hC0200000, 32'h3FC00000}, 1'b0, 1'b0, s);
        push_all({F0, 32'h3FC00000}, 1'b0, {32'hC0200000, 32'h3FC00000}, 1'b0, 1'b0, s + 12);
        q_w[$].at = s + 14;
        repeat (13) begin
            @(negedge clk);
            if (cyc == s + 11) check("a_idle_between_busy", 64'(busy_a), 64'd0);
        end
        start = 1'b0;
        drain();

        // start pulse during MAC is ignored
        @(negedge clk);
        start = 1'b1;
        push_all({F0, 32'h3FC00000}, 1'b0, {32'hC0200000, 32'h3FC00000}, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // tie at 2.0 keeps index 0; neuron1 = 3.0 wins
        set_stim(F1, F2, F0, F1, F2, F0, F0, F0);
        eval({F2, F2}, 1'b0, {F2, F2}, 1'b0, 1'b0);
        set_stim(F1, F2, F0, F1, F1, F1, F0, F0);
        eval({32'h40400000, F2}, 1'b1, {32'h40400000, F2}, 1'b1, 1'b0);

        // -0 accumulation: ReLU clamps to +0, identity keeps 0x80000000
        set_stim(F1, F2, FN0, FN0, F0, FH, FN0, F0);
        eval({F1, F0}, 1'b1, {F1, FN0}, 1'b1, 1'b0);

        // NaN neuron never wins the argmax
        set_stim(F1, F2, F1, F1, F0, FH, QN, F0);
        eval({F1, F0}, 1'b1, {F1, F0}, 1'b1, 1'b1);

        // reset during MAC of group 1 aborts with no done
        base_stim();
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 5) @(negedge clk);
        check("a_busy_before_abort", 64'(busy_a), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("abort");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done_a", 64'(busy_a | done_a), 64'd0);

        eval({F0, 32'h3FC00000}, 1'b0, {32'hC0200000, 32'h3FC00000}, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/neural_layer_mac.md
NEURAL_LAYER_MAC -- requirements
Module: neural_layer_mac

Interface
REQ-001 SHALL have parameter IN_SIZE, default 784: inputs per neuron, at least 1.
REQ-002 SHALL have parameter OUT_SIZE, default 10: neurons in the layer, at least 1.
REQ-003 SHALL have parameter LANES, default 1: neurons computed in parallel; OUT_SIZE SHALL be a multiple of LANES.
REQ-004 SHALL have parameter ACTIVATION, default 1: 0 = identity, 1 = ReLU.
REQ-005 SHALL have clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have start, input, 1 bit: request one layer evaluation.
REQ-008 SHALL have in, input, 32*IN_SIZE bits: IEEE-754 single-precision inputs; element i at [32*i +: 32].
REQ-009 SHALL have weights, input, 32*IN_SIZE*OUT_SIZE bits: weight of neuron j for input i at index j*IN_SIZE+i.
REQ-010 SHALL have bias, input, 32*OUT_SIZE bits: bias of neuron j at [32*j +: 32].
REQ-011 SHALL have busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-012 SHALL have done, output, 1 bit: single-cycle completion pulse.
REQ-013 SHALL have result, output, 32*OUT_SIZE bits: registered activated outputs; neuron j at [32*j +: 32].
REQ-014 SHALL have argmax, output, max(1,$clog2(OUT_SIZE)) bits: index of the largest result.

Function
REQ-015 SHALL implement FSM states IDLE, INIT, MAC, WB, ARG, DONE.
REQ-016 IDLE: start=1 sampled at a rising edge SHALL move the FSM to INIT with group counter g=0; start is ignored in every other state.
REQ-017 INIT (1 cycle): acc[l] SHALL load bias[g*LANES+l] for l in 0..LANES-1; input counter i SHALL clear to 0.
REQ-018 MAC (IN_SIZE cycles): each cycle acc[l] SHALL become acc[l] + in[i]*weights[(g*LANES+l)*IN_SIZE+i] using the existing combinational single-precision multiply and add units; the FSM SHALL move to WB after i = IN_SIZE-1.
REQ-019 WB (1 cycle): result[g*LANES+l] SHALL load act(acc[l]); the FSM SHALL go to ARG if g is the last group, otherwise increment g and return to INIT.
REQ-020 act SHALL be: ACTIVATION=0, pass-through; ACTIVATION=1, any value with sign bit 1 (including -0 and negative NaN) becomes 0x00000000, others pass through.
REQ-021 ARG (OUT_SIZE cycles): SHALL scan results 0..OUT_SIZE-1, replacing the running maximum only when strictly greater by float compare; ties keep the lowest index; NaN never wins; argmax SHALL update on exit.
REQ-022 DONE (1 cycle): done=1, busy=0, then IDLE; start sampled in DONE is ignored.
REQ-023 With G = OUT_SIZE/LANES, the done cycle SHALL begin exactly G*(IN_SIZE+2)+OUT_SIZE rising edges after the edge that sampled start.
REQ-024 busy SHALL be 1 in INIT, MAC, WB and ARG, and 0 in IDLE and DONE.
REQ-025 in, weights and bias SHALL be held stable by the driver while busy; the block does not capture them.
REQ-026 result and argmax SHALL hold their values between evaluations; an untouched neuron group keeps its previous value until its own WB.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, g=0, i=0, acc=0, busy=0, done=0, result=all zeros, argmax=0, overriding all other inputs including start.
REQ-028 Reset in mid-operation SHALL abort without a done pulse; a start after rst deasserts SHALL begin a fresh evaluation.

Verification
REQ-029 Parameters IN=2, OUT=2, LANES=1, ACT=1; in={1.0, 2.0}; w0={0.5, 0.5}, b0=0; w1={-1.0, -1.0}, b1=0.5; pulse start -> result0=0x3FC00000, result1=0x00000000, argmax=0, done exactly 10 edges after start.
REQ-030 Same stimulus with ACT=0 -> result1=0xC0200000, argmax=0; same stimulus with LANES=2 -> identical results, done at 6 edges.
REQ-031 Tie: both neurons produce 0x40000000 -> argmax=0; make neuron1 larger (0x40400000) -> argmax=1.
REQ-032 Hold start high throughout the REQ-029 run -> exactly one done pulse per evaluation, with IDLE re-entered between evaluations; a start pulse mid-MAC has no effect on results or timing.
REQ-033 Assert rst during MAC of group 1 -> next edge busy=0, result=0, no done; a subsequent start reproduces the REQ-029 values and timing.
